// File: rtl/ae_pkg.sv
// Shared definitions for the AE accumulator controller:
// opcodes, AE select encodings and the sequencer state type.
package ae_pkg;

    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_ADC     = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_INC     = 3'b100;
    localparam logic [2:0] OP_DEC     = 3'b101;
    localparam logic [2:0] OP_CLR     = 3'b110;
    localparam logic [2:0] OP_RPT_ADD = 3'b111;

    localparam logic [1:0] SEL_ADD      = 2'b00;
    localparam logic [1:0] SEL_SUBB     = 2'b01;
    localparam logic [1:0] SEL_XFER_INC = 2'b10;
    localparam logic [1:0] SEL_DEC      = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ae_op_decode.sv
// Combinational opcode decoder for the AE sequencer.
// Ports: op, flag_c in; sel, ci, uses_ae, is_repeat out.
module ae_op_decode
    import ae_pkg::*;
(
    input  logic [2:0] op,
    input  logic       flag_c,
    output logic [1:0] sel,
    output logic       ci,
    output logic       uses_ae,
    output logic       is_repeat
);

    always_comb begin
        sel       = SEL_ADD;
        ci        = 1'b0;
        uses_ae   = 1'b1;
        is_repeat = 1'b0;
        case (op)
            OP_LOAD:    uses_ae = 1'b0;
            OP_ADD:     ;
            OP_ADC:     ci = flag_c;
            OP_SUB: begin
                sel = SEL_SUBB;
                ci  = 1'b1;
            end
            OP_INC: begin
                sel = SEL_XFER_INC;
                ci  = 1'b1;
            end
            OP_DEC:     sel = SEL_DEC;
            OP_CLR:     uses_ae = 1'b0;
            OP_RPT_ADD: is_repeat = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: rtl/ae_acc_ctrl.sv
// Accumulator / micro-op sequencer driving the 4-bit AE.
// Ports: clk, rst_n; cmd_* handshake in; ae_* to/from AE;
// acc, flag_c, flag_z state out; busy, done status out.
module ae_acc_ctrl
    import ae_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_operand,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [WIDTH-1:0] ae_a,
    output logic [WIDTH-1:0] ae_b,
    output logic             ae_ci,
    output logic [1:0]       ae_sel,
    input  logic [WIDTH-1:0] ae_d,
    input  logic             ae_co,
    output logic [WIDTH-1:0] acc,
    output logic             flag_c,
    output logic             flag_z,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic             uses_ae_q;
    logic             rpt_q;

    logic [1:0]       dec_sel;
    logic             dec_ci;
    logic             dec_uses_ae;
    logic             dec_repeat;

    logic             accept;
    logic             last_iter;
    logic             wr_en;
    logic [WIDTH-1:0] wr_val;
    logic             wr_c;

    ae_op_decode u_dec (
        .op        (cmd_op),
        .flag_c    (flag_c),
        .sel       (dec_sel),
        .ci        (dec_ci),
        .uses_ae   (dec_uses_ae),
        .is_repeat (dec_repeat)
    );

    assign ae_a      = acc;
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign accept    = cmd_valid && cmd_ready;

    // A repeat with count 0 or 1 needs only the current EXEC cycle.
    assign last_iter = !rpt_q || (cnt <= CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        // LOAD takes its value from the operand register; CLR writes 0.
        wr_val    = uses_ae_q ? ae_d :
                    (op_q == OP_LOAD) ? ae_b : '0;
        wr_c      = uses_ae_q ? ae_co : 1'b0;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_EXEC;
            ST_EXEC: begin
                // A zero-count repeat burns its cycle without a write.
                wr_en = !rpt_q || (cnt != '0);
                if (last_iter) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            ae_b      <= '0;
            ae_sel    <= 2'b00;
            ae_ci     <= 1'b0;
            op_q      <= OP_LOAD;
            cnt       <= '0;
            uses_ae_q <= 1'b0;
            rpt_q     <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= cmd_op;
                ae_b      <= cmd_operand;
                cnt       <= cmd_count;
                ae_sel    <= dec_sel;
                ae_ci     <= dec_ci;
                uses_ae_q <= dec_uses_ae;
                rpt_q     <= dec_repeat;
            end
            if (state == ST_EXEC && !last_iter) cnt <= cnt - CNT_W'(1);
            if (wr_en) begin
                acc    <= wr_val;
                flag_c <= wr_c;
                flag_z <= (wr_val == '0);
            end
        end
    end

endmodule

// File: tb/tb_ae_acc_ctrl.sv
// Directed self-checking bench for ae_acc_ctrl with a
// behavioural 4-bit AE model closing the loop.
module tb_ae_acc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_operand;
    logic [3:0] cmd_count;
    logic [3:0] ae_a;
    logic [3:0] ae_b;
    logic       ae_ci;
    logic [1:0] ae_sel;
    logic [3:0] ae_d;
    logic       ae_co;
    logic [3:0] acc;
    logic       flag_c;
    logic       flag_z;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;
    int lat;
    int bcnt;

    localparam logic [2:0] LOAD = 3'b000;
    localparam logic [2:0] ADD  = 3'b001;
    localparam logic [2:0] ADC  = 3'b010;
    localparam logic [2:0] SUB  = 3'b011;
    localparam logic [2:0] INC  = 3'b100;
    localparam logic [2:0] DEC  = 3'b101;
    localparam logic [2:0] CLR  = 3'b110;
    localparam logic [2:0] RPT  = 3'b111;

    always #5 clk = ~clk;

    ae_acc_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .cmd_count   (cmd_count),
        .ae_a        (ae_a),
        .ae_b        (ae_b),
        .ae_ci       (ae_ci),
        .ae_sel      (ae_sel),
        .ae_d        (ae_d),
        .ae_co       (ae_co),
        .acc         (acc),
        .flag_c      (flag_c),
        .flag_z      (flag_z),
        .busy        (busy),
        .done        (done)
    );

    // AE: 00 A+B+Ci, 01 A+~B+Ci, 10 A+Ci, 11 A+1111+Ci
    logic [3:0] bm;
    always_comb begin
        bm = ae_b;
        case (ae_sel)
            2'b00: bm = ae_b;
            2'b01: bm = ~ae_b;
            2'b10: bm = 4'h0;
            2'b11: bm = 4'hF;
            default: bm = ae_b;
        endcase
        {ae_co, ae_d} = 5'(ae_a) + 5'(bm) + 5'(ae_ci);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one command from IDLE; return latency to done and busy count.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] b,
                           input logic [3:0] n);
        cmd_op      = op;
        cmd_operand = b;
        cmd_count   = n;
        cmd_valid   = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat  = 1;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = LOAD;
        cmd_operand = 4'd0;
        cmd_count   = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_acc",    32'(acc), 0);
        chk("rst_c",      32'(flag_c), 0);
        chk("rst_z",      32'(flag_z), 0);
        chk("rst_done",   32'(done), 0);
        chk("rst_ready",  32'(cmd_ready), 1);
        chk("rst_busy",   32'(busy), 0);
        chk("rst_b",      32'(ae_b), 0);
        chk("rst_sel",    32'(ae_sel), 0);
        chk("rst_ci",     32'(ae_ci), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_cmd(LOAD, 4'd5, 4'd0);
        chk("load5_acc", 32'(acc), 5);
        run_cmd(SUB, 4'd3, 4'd0);
        chk("sub_lat",   32'(lat), 2);
        chk("sub_acc",   32'(acc), 2);
        chk("sub_c",     32'(flag_c), 1);
        chk("sub_z",     32'(flag_z), 0);
        chk("sub_ready", 32'(cmd_ready), 1);
        run_cmd(LOAD, 4'd3, 4'd0);
        run_cmd(SUB, 4'd5, 4'd0);
        chk("subb_acc",  32'(acc), 14);
        chk("subb_c",    32'(flag_c), 0);
        chk("hold_sel",  32'(ae_sel), 1);
        chk("hold_ci",   32'(ae_ci), 1);
        chk("hold_b",    32'(ae_b), 5);
        chk("ae_a",      32'(ae_a), 14);

        run_cmd(LOAD, 4'd15, 4'd0);
        run_cmd(INC, 4'd0, 4'd0);
        chk("inc_acc",   32'(acc), 0);
        chk("inc_c",     32'(flag_c), 1);
        chk("inc_z",     32'(flag_z), 1);
        run_cmd(ADC, 4'd4, 4'd0);
        chk("adc_acc",   32'(acc), 5);
        chk("adc_c",     32'(flag_c), 0);
        chk("adc_ci",    32'(ae_ci), 1);
        chk("adc_z",     32'(flag_z), 0);

        run_cmd(LOAD, 4'd0, 4'd0);
        chk("load0_z",   32'(flag_z), 1);
        run_cmd(DEC, 4'd0, 4'd0);
        chk("dec_acc",   32'(acc), 15);
        chk("dec_c",     32'(flag_c), 0);
        chk("dec_z",     32'(flag_z), 0);
        run_cmd(CLR, 4'd0, 4'd0);
        chk("clr_acc",   32'(acc), 0);
        chk("clr_c",     32'(flag_c), 0);
        chk("clr_z",     32'(flag_z), 1);

        run_cmd(CLR, 4'd0, 4'd0);
        run_cmd(RPT, 4'd3, 4'd6);
        chk("rpt6_lat",  32'(lat), 7);
        chk("rpt6_busy", 32'(bcnt), 7);
        chk("rpt6_acc",  32'(acc), 2);
        chk("rpt6_c",    32'(flag_c), 1);
        chk("rpt6_z",    32'(flag_z), 0);

        run_cmd(LOAD, 4'd12, 4'd0);
        run_cmd(ADD, 4'd13, 4'd0);
        chk("add_acc",   32'(acc), 9);
        chk("add_c",     32'(flag_c), 1);
        run_cmd(RPT, 4'd3, 4'd0);
        chk("rpt0_lat",  32'(lat), 2);
        chk("rpt0_acc",  32'(acc), 9);
        chk("rpt0_c",    32'(flag_c), 1);
        chk("rpt0_z",    32'(flag_z), 0);

        // valid held through busy: second accept only after IDLE
        cmd_op      = LOAD;
        cmd_operand = 4'd6;
        cmd_valid   = 1'b1;
        @(posedge clk); #1;
        chk("hv_busy1",  32'(busy), 1);
        chk("hv_rdy0",   32'(cmd_ready), 0);
        cmd_operand = 4'd1;
        @(posedge clk); #1;
        chk("hv_done",   32'(done), 1);
        chk("hv_acc6",   32'(acc), 6);
        @(posedge clk); #1;
        chk("hv_ready",  32'(cmd_ready), 1);
        chk("hv_acc6b",  32'(acc), 6);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("hv_busy2",  32'(busy), 1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("hv_acc1",   32'(acc), 1);
        chk("hv_idle",   32'(busy), 0);

        // reset during the 4th EXEC cycle of a long repeat
        run_cmd(CLR, 4'd0, 4'd0);
        cmd_op      = RPT;
        cmd_operand = 4'd1;
        cmd_count   = 4'd10;
        cmd_valid   = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("mid_acc",   32'(acc), 3);
        chk("mid_busy",  32'(busy), 1);
        rst_n       = 1'b0;
        cmd_op      = LOAD;
        cmd_operand = 4'd7;
        cmd_valid   = 1'b1;
        @(posedge clk); #1;
        chk("mr_acc",    32'(acc), 0);
        chk("mr_c",      32'(flag_c), 0);
        chk("mr_z",      32'(flag_z), 0);
        chk("mr_done",   32'(done), 0);
        chk("mr_ready",  32'(cmd_ready), 1);
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("mr_drop",   32'(acc), 0);
        chk("mr_idle",   32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ae_acc_ctrl.md
Name: ae_acc_ctrl

Overview:
Accumulator and micro-operation sequencer that sits directly upstream of the 4-bit arithmetic circuit (AE). It accepts commands over a valid/ready handshake and drives the AE operand, select and carry-in inputs. It captures the AE sum and carry back into an accumulator with carry and zero flags, and runs multi-cycle repeated-add commands.

Parameters:
WIDTH, 4, datapath width; must equal the AE data width.
CNT_W, 4, width of the repeat count for RPT_ADD.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst_n  input  1  synchronous, active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  high exactly when state is IDLE.
cmd_op  input  3  opcode (see Behaviour).
cmd_operand  input  WIDTH  B operand, or load value for LOAD.
cmd_count  input  CNT_W  iteration count; RPT_ADD only.
ae_a  output  WIDTH  to AE A; always equals acc.
ae_b  output  WIDTH  to AE B; registered operand.
ae_ci  output  1  to AE Ci.
ae_sel  output  2  to AE Sel.
ae_d  input  WIDTH  AE sum.
ae_co  input  1  AE carry out.
acc  output  WIDTH  accumulator.
flag_c  output  1  carry flag.
flag_z  output  1  zero flag; registered, updated with acc.
busy  output  1  high in EXEC and DONE.
done  output  1  one-cycle pulse at command completion.

Behaviour:
- Reset: rst_n low at an edge gives state IDLE and acc, flag_c, flag_z, done, ae_b, ae_ci, ae_sel all 0. flag_z resets to 0 even though acc=0. Reset overrides any command in flight; a command offered during the reset cycle is dropped.
- Opcodes and AE drive (Sel, Ci):
  - 000 LOAD: acc<=operand, flag_c<=0; AE unused.
  - 001 ADD: (00, 0).
  - 010 ADC: (00, flag_c as sampled at accept).
  - 011 SUB: (01, 1); co=1 means no borrow.
  - 100 INC: (10, 1).
  - 101 DEC: (11, 0).
  - 110 CLR: acc<=0, flag_c<=0; AE unused.
  - 111 RPT_ADD: (00, 0), repeated cmd_count times.
- FSM states IDLE -> EXEC -> DONE -> IDLE.
  - IDLE: a command is accepted when cmd_valid and cmd_ready are both high. On accept, register op, operand and count, and set ae_sel/ae_ci.
  - EXEC: the AE is combinational. Each EXEC cycle writes acc<=ae_d and flag_c<=ae_co for AE ops; LOAD and CLR write as listed above. flag_z<=(new acc==0) on every write.
  - Single ops spend exactly 1 EXEC cycle.
  - RPT_ADD spends max(count,1) EXEC cycles, decrementing the internal counter each cycle. count=0 gives one EXEC cycle with no write, leaving acc and flags unchanged.
  - DONE: done=1 for one cycle, cmd_ready=0, then IDLE.
- Latency: accept at cycle T; acc is valid after the T+1 edge for single ops; done is high during T+2. The next accept is possible at T+3. For RPT_ADD with count N>=1, done is high during T+N+1.
- Arithmetic wraps modulo 2^WIDTH. flag_c reflects the carry from the final iteration only.
- ae_a tracks acc continuously. ae_b, ae_sel and ae_ci hold their last values while IDLE.

Decomposition:
- Shared package ae_pkg holds:
  - opcode localparams OP_LOAD..OP_RPT_ADD;
  - Sel encodings SEL_ADD=00, SEL_SUBB=01, SEL_XFER_INC=10, SEL_DEC=11;
  - the FSM state enum.
- One sub-module, ae_op_decode: combinational op plus flag_c to {sel, ci, uses_ae, is_repeat}.

Test Plan:
- LOAD 5, then SUB 3 -> acc=2, flag_c=1, flag_z=0; done pulses exactly 2 cycles after the accept cycle. Then LOAD 3, SUB 5 -> acc=14, flag_c=0.
- LOAD 15, INC -> acc=0, flag_c=1, flag_z=1. Then ADC with operand 4 -> acc=5, flag_c=0.
- LOAD 0, DEC -> acc=15, flag_c=0. Then CLR -> acc=0, flag_c=0, flag_z=1.
- CLR, then RPT_ADD operand=3, count=6 -> 6 EXEC cycles (busy high 7 cycles), final acc=2, flag_c=1 (the 6th add wraps 15+3).
- RPT_ADD count=0 with acc=9 -> acc=9 and flags unchanged, done 2 cycles after accept. Also check: cmd_valid held high through busy is not accepted until cmd_ready returns.
- Start RPT_ADD count=10, assert rst_n low on the 4th EXEC cycle -> next cycle acc=0, flags 0, done=0, cmd_ready=1. A command offered in the reset cycle is not executed.
